// File: rtl/instr_adder_pkg.sv
// Shared types and defaults for the instrumented-adder ring measurement.
// FSM encoding, ring width and default timing constants.
package instr_adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_COUNT  = 2'd2,
      ST_DONE   = 2'd3
   } meas_state_e;

   localparam int RING_W     = 8;
   localparam int DEF_SETTLE = 16;
   localparam int DEF_WINDOW = 1024;
   localparam int DEF_CNT_W  = 16;

   function automatic int cnt_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ring_edge_sync.sv
// Two-flop synchronizer for one ring bit plus rising-edge pulse.
// The prev flop always follows the synced level.
module ring_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic sync,
   output logic rise
);

   logic ff1_q;
   logic ff2_q;
   logic prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ff1_q  <= 1'b0;
         ff2_q  <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         ff1_q  <= din;
         ff2_q  <= ff1_q;
         prev_q <= ff2_q;
      end
   end

   assign sync = ff2_q;
   assign rise = ff2_q & ~prev_q;

endmodule

// File: rtl/adder_ring_meas_ctrl.sv
// Ring oscillator measurement sequencer: apply enables, settle,
// count rising edges of one ring bit over a fixed window.
module adder_ring_meas_ctrl
   import instr_adder_pkg::*;
#(
   parameter int SETTLE_CYCLES = DEF_SETTLE,
   parameter int WINDOW_CYCLES = DEF_WINDOW,
   parameter int CNT_W         = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [7:0]        cfg_xor,
   input  logic [7:0]        cfg_add,
   input  logic [2:0]        cfg_bit,
   input  logic [RING_W-1:0] ring_out,
   output logic [7:0]        xor_enable,
   output logic [7:0]        add_enable,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  count,
   output logic              overflow
);

   localparam int TMAX = (SETTLE_CYCLES > WINDOW_CYCLES) ?
                         SETTLE_CYCLES : WINDOW_CYCLES;
   localparam int TW   = cnt_bits(TMAX);

   localparam logic [TW-1:0] SET_LAST = TW'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0] WIN_LAST = TW'(WINDOW_CYCLES - 1);

   meas_state_e      state_q, state_d;
   logic [TW-1:0]    tmr_q, tmr_d;
   logic [7:0]       xor_q, xor_d;
   logic [7:0]       add_q, add_d;
   logic [2:0]       bit_q;
   logic             bit_ld;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;

   logic ring_sel;
   logic ring_sync;
   logic ring_rise;
   logic edge_hit;

   assign ring_sel = ring_out[bit_q];

   ring_edge_sync u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (ring_sel),
      .sync  (ring_sync),
      .rise  (ring_rise)
   );

   assign edge_hit = ring_rise & ring_sync;

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      xor_d   = xor_q;
      add_d   = add_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      bit_ld  = 1'b0;
      if (abort) begin
         state_d = ST_IDLE;
         tmr_d   = '0;
         xor_d   = '0;
         add_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_d = ST_SETTLE;
                  tmr_d   = '0;
                  xor_d   = cfg_xor;
                  add_d   = cfg_add;
                  cnt_d   = '0;
                  ovf_d   = 1'b0;
                  bit_ld  = 1'b1;
               end
            end
            ST_SETTLE: begin
               if (tmr_q == SET_LAST) begin
                  state_d = ST_COUNT;
                  tmr_d   = '0;
               end else begin
                  tmr_d = tmr_q + 1'b1;
               end
            end
            ST_COUNT: begin
               if (edge_hit) begin
                  if (&cnt_q) ovf_d = 1'b1;
                  else        cnt_d = cnt_q + 1'b1;
               end
               if (tmr_q == WIN_LAST) begin
                  state_d = ST_DONE;
                  tmr_d   = '0;
                  xor_d   = '0;
                  add_d   = '0;
               end else begin
                  tmr_d = tmr_q + 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         tmr_q   <= '0;
         xor_q   <= '0;
         add_q   <= '0;
         bit_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         xor_q   <= xor_d;
         add_q   <= add_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         if (bit_ld) bit_q <= cfg_bit;
      end
   end

   assign xor_enable = xor_q;
   assign add_enable = add_q;
   assign busy       = (state_q == ST_SETTLE) || (state_q == ST_COUNT);
   assign done       = (state_q == ST_DONE);
   assign count      = cnt_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_adder_ring_meas_ctrl.sv
// Directed bench for adder_ring_meas_ctrl with a toggling ring model.
// Two instances: main timing (16-bit count) and 4-bit saturation.
module tb_adder_ring_meas_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, start_s, abort;
   logic [7:0]  cfg_xor, cfg_add;
   logic [2:0]  cfg_bit;
   logic [7:0]  ring_out;

   logic [7:0]  xor_en, add_en, xor_en_s, add_en_s;
   logic        busy, done, ovf, busy_s, done_s, ovf_s;
   logic [15:0] count;
   logic [3:0]  count_s;

   int n_run  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int half   = 0;
   int ph     = 0;
   int rbit   = 0;

   always #5 clk = ~clk;

   adder_ring_meas_ctrl #(
      .SETTLE_CYCLES (4),
      .WINDOW_CYCLES (64),
      .CNT_W         (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .cfg_xor    (cfg_xor),
      .cfg_add    (cfg_add),
      .cfg_bit    (cfg_bit),
      .ring_out   (ring_out),
      .xor_enable (xor_en),
      .add_enable (add_en),
      .busy       (busy),
      .done       (done),
      .count      (count),
      .overflow   (ovf)
   );

   adder_ring_meas_ctrl #(
      .SETTLE_CYCLES (4),
      .WINDOW_CYCLES (128),
      .CNT_W         (4)
   ) dut_s (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start_s),
      .abort      (abort),
      .cfg_xor    (cfg_xor),
      .cfg_add    (cfg_add),
      .cfg_bit    (cfg_bit),
      .ring_out   (ring_out),
      .xor_enable (xor_en_s),
      .add_enable (add_en_s),
      .busy       (busy_s),
      .done       (done_s),
      .count      (count_s),
      .overflow   (ovf_s)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_run++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Ring bit rbit toggles every 'half' clocks; half=0 holds it.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (half > 0) begin
         ph++;
         if (ph >= half) begin
            ph = 0;
            ring_out[rbit] = ~ring_out[rbit];
         end
      end
   endtask

   task automatic go(input logic [7:0] x, input logic [7:0] a,
                     input logic [2:0] b, input bit sat);
      tick();
      cfg_xor = x;
      cfg_add = a;
      cfg_bit = b;
      if (sat) start_s = 1'b1;
      else     start   = 1'b1;
      tick();
      start   = 1'b0;
      start_s = 1'b0;
      cyc     = 1;
   endtask

   task automatic run_to(input int c);
      while (cyc < c) tick();
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_cnt"},  32'(count), 32'd0);
      chk({tag, "_ovf"},  32'(ovf), 32'd0);
      chk({tag, "_en"},   {16'd0, xor_en, add_en}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; start_s = 1'b0; abort = 1'b0;
      cfg_xor = '0; cfg_add = '0; cfg_bit = '0; ring_out = '0;
      repeat (3) tick();
      chk_idle("rst");
      rst_n = 1'b1;
      tick();

      // basic run: bit 3 period 8
      half = 4; ph = 0; rbit = 3;
      go(8'h01, 8'hFF, 3'd3, 1'b0);
      chk("b_en1", {16'd0, xor_en, add_en}, 32'h01FF);
      chk("b_busy1", 32'(busy), 32'd1);
      cfg_xor = 8'h5C; cfg_add = 8'h3E; cfg_bit = 3'd6;
      run_to(68);
      chk("b_en68", {16'd0, xor_en, add_en}, 32'h01FF);
      chk("b_done68", 32'(done), 32'd0);
      tick();
      chk("b_done69", 32'(done), 32'd1);
      chk("b_busy69", 32'(busy), 32'd0);
      chk("b_en69", {16'd0, xor_en, add_en}, 32'd0);
      chk("b_cnt", 32'(count), 32'd8);
      chk("b_ovf", 32'(ovf), 32'd0);

      // restart from DONE, then start during COUNT is ignored
      go(8'hA5, 8'h5A, 3'd3, 1'b0);
      chk("r_cnt_clr", 32'(count), 32'd0);
      run_to(10);
      tick();
      cfg_xor = 8'h33; cfg_add = 8'hCC; cfg_bit = 3'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("ig_en", {16'd0, xor_en, add_en}, 32'hA55A);
      run_to(69);
      chk("ig_done69", 32'(done), 32'd1);
      chk("ig_cnt", 32'(count), 32'd8);

      // level high through the window is not an edge
      half = 0; ring_out = 8'hFF;
      go(8'h11, 8'h22, 3'd5, 1'b0);
      run_to(69);
      chk("hi_done", 32'(done), 32'd1);
      chk("hi_cnt", 32'(count), 32'd0);

      // 0->1 landing on the last window cycle is counted
      ring_out = 8'h00;
      go(8'h11, 8'h22, 3'd2, 1'b0);
      run_to(66);
      ring_out[2] = 1'b1;
      run_to(69);
      chk("last_done", 32'(done), 32'd1);
      chk("last_cnt", 32'(count), 32'd1);

      // abort and start together from DONE: abort wins
      tick();
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      chk_idle("abst");

      // abort mid-run
      ring_out = 8'h00; half = 4; ph = 0; rbit = 3;
      go(8'h0F, 8'hF0, 3'd3, 1'b0);
      run_to(20);
      chk("ab_busy", 32'(busy), 32'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk_idle("ab");

      // async reset mid-COUNT
      go(8'h0F, 8'hF0, 3'd3, 1'b0);
      run_to(30);
      chk("ar_cnt_pre", 32'(count != 16'd0), 32'd1);
      #1 rst_n = 1'b0;
      #1 chk_idle("ar");
      tick();
      rst_n = 1'b1;
      tick();

      // saturation: 4-bit count, period 4, 128-cycle window
      ring_out = 8'h00; half = 2; ph = 0; rbit = 1;
      go(8'h77, 8'h88, 3'd1, 1'b1);
      chk("s_en1", {16'd0, xor_en_s, add_en_s}, 32'h7788);
      while (!done_s && cyc < 200) tick();
      chk("s_lat", 32'(cyc), 32'd133);
      chk("s_cnt", 32'(count_s), 32'd15);
      chk("s_ovf", 32'(ovf_s), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
